// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FSM state encoding, minimum bit period and parity modes.
// Used by the RX engine, the register block and the TX engine.
package uart_pkg;

    localparam int unsigned UART_MIN_PERIOD = 4;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } uart_rx_state_e;

    typedef enum logic {
        PARITY_NONE = 1'b0,
        PARITY_EVEN = 1'b1
    } uart_parity_e;

    function automatic logic [15:0] clamp_period(input logic [15:0] period,
                                                 input logic [15:0] min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line plus a falling-edge detect on the
// synchronized value. The line idles high, so every stage powers up and resets to 1.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_s_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o   = sync_q[SYNC_STAGES-1];
    assign fall_s_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive sequencer: start/data/parity/stop FSM with a per-frame latched configuration,
// delivering one byte plus parity/frame/overrun status to the register block.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned MIN_PERIOD  = UART_MIN_PERIOD,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic [15:0] cfg_period_i,
    input  logic        cfg_parity_en_i,
    input  logic        cfg_stop2_i,
    input  logic        rx_ack_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        busy_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam logic [15:0] MinPeriod = 16'(MIN_PERIOD);

    logic rx_s;
    logic fall_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rx_i    (rx_i),
        .rx_s_o  (rx_s),
        .fall_s_o(fall_s)
    );

    uart_rx_state_e state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    period_q, period_d;
    uart_parity_e   parity_q, parity_d;
    logic           stop2_q, stop2_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_err_q, par_err_d;
    logic           frame_err_q, frame_err_d;
    logic           done_q, done_d;

    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;

    logic [15:0]    period_eff;
    logic           sample;

    assign period_eff = clamp_period(cfg_period_i, MinPeriod);
    assign sample     = (cnt_q == 16'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        parity_d    = parity_q;
        stop2_d     = stop2_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = ovr_q;

        if (state_q != RX_IDLE && !sample) begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_s) begin
                    state_d     = RX_START;
                    period_d    = period_eff;
                    cnt_d       = period_eff >> 1;
                    parity_d    = cfg_parity_en_i ? PARITY_EVEN : PARITY_NONE;
                    stop2_d     = cfg_stop2_i;
                    bit_cnt_d   = 3'd0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            RX_START: begin
                if (sample) begin
                    // A high line at mid-start is a glitch: drop back silently.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                    cnt_d   = period_q;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = period_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (parity_q == PARITY_EVEN) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (sample) begin
                    par_err_d = (^shift_q) ^ rx_s;
                    cnt_d     = period_q;
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample) begin
                    frame_err_d = frame_err_q | ~rx_s;
                    // bit_cnt wrapped to 0 after the data bits; reuse it to count stop bits.
                    if (stop2_q && bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd1;
                        cnt_d     = period_q;
                    end else begin
                        state_d = RX_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Completion beats a coincident ack; the ack only suppresses the overrun.
        if (done_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = par_err_q;
            ferr_d  = frame_err_q;
            ovr_d   = ~rx_ack_i & (ovr_q | valid_q);
        end else if (rx_ack_i) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            period_q    <= MinPeriod;
            parity_q    <= PARITY_NONE;
            stop2_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            parity_q    <= parity_d;
            stop2_q     <= stop2_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign busy_o       = (state_q != RX_IDLE);
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed vector table, hand-written corner sequences
// and randomized frames compared against a frame-level reference model.
module tb_uart_rx_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic [15:0] cfg_period_i;
    logic        cfg_parity_en_i;
    logic        cfg_stop2_i;
    logic        rx_ack_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        busy_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_o;

    always #5 clk_i = ~clk_i;

    uart_rx_engine dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .cfg_period_i   (cfg_period_i),
        .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_stop2_i    (cfg_stop2_i),
        .rx_ack_i       (rx_ack_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .busy_o         (busy_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_o      (overrun_o)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int frame_start = 0;
    int rise_cyc    = -1;
    int busy_rise   = -1;
    int busy_fall   = -1;
    bit valid_prev  = 1'b0;
    bit busy_prev   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Edge timestamps are taken on the falling clock, away from the DUT's active edge.
    always @(negedge clk_i) begin
        if (rx_valid_o && !valid_prev) rise_cyc = cyc;
        if (busy_o && !busy_prev) busy_rise = cyc;
        if (!busy_o && busy_prev) busy_fall = cyc;
        valid_prev = rx_valid_o;
        busy_prev  = busy_o;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk_i);
        rx_ack_i = 1'b1;
        @(negedge clk_i);
        rx_ack_i = 1'b0;
    endtask

    // Drives one whole frame, bit edges on the falling clock, then a quiet gap on the line.
    task automatic send_frame(input logic [7:0] d, input int cfg_p, input bit par_en,
                              input bit par_bit, input bit stop2, input bit [1:0] stop_val,
                              input bit scramble);
        int p;
        p = (cfg_p < 4) ? 4 : cfg_p;
        @(negedge clk_i);
        cfg_period_i    = 16'(cfg_p);
        cfg_parity_en_i = par_en;
        cfg_stop2_i     = stop2;
        @(negedge clk_i);
        rx_i        = 1'b0;
        frame_start = cyc;
        rise_cyc    = -1;
        busy_rise   = -1;
        busy_fall   = -1;
        repeat (p) @(negedge clk_i);
        if (scramble) begin
            cfg_period_i    = 16'($urandom_range(1, 40));
            cfg_parity_en_i = ~par_en;
            cfg_stop2_i     = ~stop2;
        end
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (p) @(negedge clk_i);
        end
        if (par_en) begin
            rx_i = par_bit;
            repeat (p) @(negedge clk_i);
        end
        rx_i = stop_val[0];
        repeat (p) @(negedge clk_i);
        if (stop2) begin
            rx_i = stop_val[1];
            repeat (p) @(negedge clk_i);
        end
        rx_i = 1'b1;
        repeat (p + 6) @(negedge clk_i);
    endtask

    // Clocks from the first edge that sees rx low until rx_valid rises.
    function automatic int model_latency(input int cfg_p, input bit par_en, input bit stop2);
        int p;
        p = (cfg_p < 4) ? 4 : cfg_p;
        return 2 + p / 2 + (9 + int'(par_en) + int'(stop2)) * p + 1;
    endfunction

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         par_en;
        bit         par_bit;
        bit         stop2;
        bit [1:0]   stop_val;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    bit         m_pend;
    bit         m_ovr;
    logic [7:0] r_data;
    int         r_p;
    bit         r_par, r_pbit, r_stop2, r_ack, r_scr;
    bit [1:0]   r_sv;
    bit         e_perr, e_ferr;

    initial begin
        vecs[0] = '{8'hA5, 16, 1'b0, 1'b0, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 155};
        vecs[1] = '{8'h07, 16, 1'b1, 1'b0, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0, 171};
        vecs[2] = '{8'h07, 16, 1'b1, 1'b1, 1'b0, 2'b11, 8'h07, 1'b0, 1'b0, 171};
        vecs[3] = '{8'h3C, 10, 1'b0, 1'b0, 1'b1, 2'b01, 8'h3C, 1'b0, 1'b1, 108};
        vecs[4] = '{8'h5A,  1, 1'b0, 1'b0, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0,  41};
        vecs[5] = '{8'h00,  7, 1'b1, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0,  76};
        vecs[6] = '{8'hFF,  5, 1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b0,  60};

        rst_i           = 1'b1;
        rx_i            = 1'b1;
        cfg_period_i    = 16'd16;
        cfg_parity_en_i = 1'b0;
        cfg_stop2_i     = 1'b0;
        rx_ack_i        = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset outputs", {rx_data_o, rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_o}, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("idle after reset", {rx_valid_o, busy_o}, 0);

        for (int i = 0; i < 7; i++) begin
            pulse_ack();
            send_frame(vecs[i].data, vecs[i].period, vecs[i].par_en, vecs[i].par_bit,
                       vecs[i].stop2, vecs[i].stop_val, 1'b0);
            check($sformatf("vec%0d data", i), rx_data_o, vecs[i].exp_data);
            check($sformatf("vec%0d valid", i), rx_valid_o, 1);
            check($sformatf("vec%0d parity_err", i), parity_err_o, vecs[i].exp_perr);
            check($sformatf("vec%0d frame_err", i), frame_err_o, vecs[i].exp_ferr);
            check($sformatf("vec%0d overrun", i), overrun_o, 0);
            check($sformatf("vec%0d latency", i), rise_cyc - (frame_start + 1), vecs[i].exp_lat);
            check($sformatf("vec%0d busy rise", i), busy_rise - (frame_start + 1), 2);
            check($sformatf("vec%0d busy fall", i), busy_fall - (frame_start + 1), vecs[i].exp_lat - 1);
        end

        // Overrun, then an ack clears every status flag.
        pulse_ack();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        send_frame(8'h22, 8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        check("overrun data", rx_data_o, 8'h22);
        check("overrun flag", overrun_o, 1);
        check("overrun errs", {parity_err_o, frame_err_o}, 2'b11);
        pulse_ack();
        @(negedge clk_i);
        check("ack clears", {rx_valid_o, parity_err_o, frame_err_o, overrun_o}, 0);
        pulse_ack();
        check("ack idle no effect", {rx_valid_o, overrun_o}, 0);

        // A 3-clock low pulse is rejected at the mid-start sample.
        @(negedge clk_i);
        cfg_period_i = 16'd16;
        @(negedge clk_i);
        rx_i        = 1'b0;
        frame_start = cyc;
        busy_rise   = -1;
        busy_fall   = -1;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("glitch busy rise", busy_rise - (frame_start + 1), 2);
        check("glitch busy fall", busy_fall - (frame_start + 1), 10);
        check("glitch no valid", {rx_valid_o, busy_o}, 0);

        // Reset in the middle of a frame, with a byte and a frame error pending.
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("pre-reset pending", {rx_valid_o, frame_err_o}, 2'b11);
        @(negedge clk_i);
        cfg_period_i = 16'd16;
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (16) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (16 * 4 + 8) @(negedge clk_i);
        check("mid-frame busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("async reset outputs", {rx_data_o, rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_o}, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (200) @(negedge clk_i);
        check("post-reset quiet", {rx_valid_o, busy_o}, 0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        check("post-reset data", rx_data_o, 8'h81);
        check("post-reset flags", {rx_valid_o, parity_err_o, frame_err_o, overrun_o}, 4'b1000);
        check("post-reset latency", rise_cyc - (frame_start + 1), 155);

        // Ack landing in the completion cycle: completion wins, no overrun.
        fork
            send_frame(8'h4E, 6, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
            begin
                wait (rx_i == 1'b0);
                repeat (model_latency(6, 1'b0, 1'b0) - 1) @(negedge clk_i);
                rx_ack_i = 1'b1;
                @(negedge clk_i);
                rx_ack_i = 1'b0;
            end
        join
        check("ack+complete data", rx_data_o, 8'h4E);
        check("ack+complete flags", {rx_valid_o, parity_err_o, frame_err_o, overrun_o}, 4'b1000);

        // Randomized frames against the frame-level model.
        pulse_ack();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            r_data  = 8'($urandom_range(0, 255));
            r_p     = $urandom_range(1, 12);
            r_par   = 1'($urandom_range(0, 1));
            r_pbit  = 1'($urandom_range(0, 1));
            r_stop2 = 1'($urandom_range(0, 1));
            r_sv[0] = ($urandom_range(0, 7) != 0);
            r_sv[1] = ($urandom_range(0, 7) != 0);
            r_ack   = 1'($urandom_range(0, 1));
            r_scr   = 1'($urandom_range(0, 1));
            if (r_ack) begin
                pulse_ack();
                m_pend = 1'b0;
                m_ovr  = 1'b0;
            end
            send_frame(r_data, r_p, r_par, r_pbit, r_stop2, r_sv, r_scr);
            m_ovr  = m_ovr | m_pend;
            m_pend = 1'b1;
            e_perr = r_par && ((^r_data) != r_pbit);
            e_ferr = !r_sv[0] || (r_stop2 && !r_sv[1]);
            check($sformatf("rnd%0d data", n), rx_data_o, r_data);
            check($sformatf("rnd%0d valid", n), rx_valid_o, m_pend);
            check($sformatf("rnd%0d parity_err", n), parity_err_o, e_perr);
            check($sformatf("rnd%0d frame_err", n), frame_err_o, e_ferr);
            check($sformatf("rnd%0d overrun", n), overrun_o, m_ovr);
            if (r_ack) begin
                check($sformatf("rnd%0d latency", n), rise_cyc - (frame_start + 1),
                      model_latency(r_p, r_par, r_stop2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
